// File: rtl/systolic_result_streamer_if.sv
// rtl/systolic_result_streamer_if.sv - matrix capture and beat stream bundle for systolic_result_streamer
// SYSTOLIC_STREAMER_OVERRUN_EN adds o_overrun / i_clearOverrun.
interface systolic_result_streamer_if #(
    parameter int N              = 4,
    parameter int ELEM_W         = 8,
    parameter int ELEMS_PER_BEAT = 1
);
    logic [N-1:0][N-1:0][ELEM_W-1:0]   i_c;
    logic                              i_resultValid;
    logic [ELEMS_PER_BEAT*ELEM_W-1:0]  o_data;
    logic                              o_valid;
    logic                              i_ready;
    logic                              o_last;
    logic                              o_canAccept;
`ifdef SYSTOLIC_STREAMER_OVERRUN_EN
    logic                              o_overrun;
    logic                              i_clearOverrun;
`endif

    modport master (
        input  i_c, i_resultValid, i_ready,
`ifdef SYSTOLIC_STREAMER_OVERRUN_EN
        input  i_clearOverrun,
        output o_overrun,
`endif
        output o_data, o_valid, o_last, o_canAccept
    );

    modport slave (
        output i_c, i_resultValid, i_ready,
`ifdef SYSTOLIC_STREAMER_OVERRUN_EN
        output i_clearOverrun,
        input  o_overrun,
`endif
        input  o_data, o_valid, o_last, o_canAccept
    );
endinterface

// File: rtl/systolic_result_streamer.sv
// rtl/systolic_result_streamer.sv - double-buffered row-major drain of a systolic result matrix
// SYSTOLIC_STREAMER_OVERRUN_EN adds a sticky dropped-capture flag with registered clear.
module systolic_result_streamer #(
    parameter int N              = 4,
    parameter int ELEM_W         = 8,
    parameter int ELEMS_PER_BEAT = 1
) (
    input  logic                      i_clk,
    input  logic                      i_srst,
    systolic_result_streamer_if.master bus
);
    localparam int BEATS  = N * N / ELEMS_PER_BEAT;
    localparam int BEAT_W = ELEMS_PER_BEAT * ELEM_W;
    localparam int CW     = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

    typedef enum logic [1:0] {IDLE, STREAM, STREAM_PEND} state_t;

    state_t                       state;
    logic [BEATS-1:0][BEAT_W-1:0] active;
    logic [BEATS-1:0][BEAT_W-1:0] pending;
    logic [CW-1:0]                beat_cnt;
    logic                         valid_q;
    logic                         can_accept_q;
    logic                         handshake;
    logic                         last_handshake;

    assign handshake      = valid_q & bus.i_ready;
    assign last_handshake = handshake & (beat_cnt == LAST_BEAT);

    // Flat packing puts element 0 in the low bits, so beat k is simply slice k.
    assign bus.o_data      = active[beat_cnt];
    assign bus.o_valid     = valid_q;
    assign bus.o_last      = valid_q & (beat_cnt == LAST_BEAT);
    assign bus.o_canAccept = can_accept_q;

    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            state        <= IDLE;
            active       <= '0;
            pending      <= '0;
            beat_cnt     <= '0;
            valid_q      <= 1'b0;
            can_accept_q <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.i_resultValid) begin
                        active   <= bus.i_c;
                        beat_cnt <= '0;
                        valid_q  <= 1'b1;
                        state    <= STREAM;
                    end
                end
                STREAM: begin
                    if (last_handshake) begin
                        beat_cnt <= '0;
                        // A capture landing on the final beat reloads active with no bubble.
                        if (bus.i_resultValid) begin
                            active <= bus.i_c;
                        end else begin
                            valid_q <= 1'b0;
                            state   <= IDLE;
                        end
                    end else begin
                        if (handshake) begin
                            beat_cnt <= beat_cnt + CW'(1);
                        end
                        if (bus.i_resultValid) begin
                            pending      <= bus.i_c;
                            can_accept_q <= 1'b0;
                            state        <= STREAM_PEND;
                        end
                    end
                end
                STREAM_PEND: begin
                    if (last_handshake) begin
                        beat_cnt <= '0;
                        active   <= pending;
                        if (bus.i_resultValid) begin
                            pending <= bus.i_c;
                        end else begin
                            can_accept_q <= 1'b1;
                            state        <= STREAM;
                        end
                    end else if (handshake) begin
                        beat_cnt <= beat_cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SYSTOLIC_STREAMER_OVERRUN_EN
    logic overrun_q;

    // A drop in the same cycle as a clear keeps the flag set.
    always_ff @(posedge i_clk) begin
        if (i_srst) begin
            overrun_q <= 1'b0;
        end else if ((state == STREAM_PEND) && bus.i_resultValid && !last_handshake) begin
            overrun_q <= 1'b1;
        end else if (bus.i_clearOverrun) begin
            overrun_q <= 1'b0;
        end
    end

    assign bus.o_overrun = overrun_q;
`endif
endmodule

// File: tb/tb_systolic_result_streamer.sv
// tb/tb_systolic_result_streamer.sv - scoreboard bench for systolic_result_streamer (EPB=1 and EPB=4)
module tb_systolic_result_streamer;
    localparam int N      = 4;
    localparam int ELEM_W = 8;
    localparam int MW     = N * N * ELEM_W;
    typedef logic [MW-1:0] mat_t;

    logic clk = 1'b0;
    logic srst;
    always #5 clk = ~clk;

    systolic_result_streamer_if #(.N(N), .ELEM_W(ELEM_W), .ELEMS_PER_BEAT(1)) b1 ();
    systolic_result_streamer_if #(.N(N), .ELEM_W(ELEM_W), .ELEMS_PER_BEAT(4)) b4 ();

    systolic_result_streamer #(.N(N), .ELEM_W(ELEM_W), .ELEMS_PER_BEAT(1)) dut1 (
        .i_clk(clk), .i_srst(srst), .bus(b1));
    systolic_result_streamer #(.N(N), .ELEM_W(ELEM_W), .ELEMS_PER_BEAT(4)) dut4 (
        .i_clk(clk), .i_srst(srst), .bus(b4));

    int vectors     = 0;
    int miscompares = 0;
    int hs_count    = 0;

    logic [ELEM_W-1:0] exp_q[$];
    logic              exp_last_q[$];
    logic [31:0]       exp4_q[$];
    bit                in_stream  = 1'b0;
    bit                prev_stall = 1'b0;
    logic [ELEM_W-1:0] prev_data;
    logic              prev_last;

    function automatic mat_t mat_rc();
        mat_t m;
        for (int e = 0; e < N * N; e++) m[e*ELEM_W +: ELEM_W] = 8'(16 * (e / N) + e % N);
        return m;
    endfunction

    function automatic mat_t mat_fill(input logic [7:0] v);
        mat_t m;
        for (int e = 0; e < N * N; e++) m[e*ELEM_W +: ELEM_W] = v;
        return m;
    endfunction

    function automatic mat_t mat_rand();
        mat_t m;
        for (int w = 0; w < MW / 32; w++) m[w*32 +: 32] = $urandom;
        return m;
    endfunction

    task automatic push_matrix(input mat_t m);
        for (int e = 0; e < N * N; e++) begin
            exp_q.push_back(m[e*ELEM_W +: ELEM_W]);
            exp_last_q.push_back(e == N * N - 1);
        end
    endtask

    task automatic push_matrix4(input mat_t m);
        logic [31:0] beat;
        for (int k = 0; k < N * N / 4; k++) begin
            for (int j = 0; j < 4; j++) beat[j*8 +: 8] = m[(k*4 + j)*ELEM_W +: ELEM_W];
            exp4_q.push_back(beat);
        end
    endtask

    // One EPB=1 clock: check outputs at negedge, drive inputs, score any handshake.
    task automatic cycle(input bit rv, input mat_t m, input bit rdy);
        logic [ELEM_W-1:0] ed;
        logic              el;
        @(negedge clk);
        if (prev_stall) begin
            vectors++;
            if (b1.o_valid !== 1'b1 || b1.o_data !== prev_data || b1.o_last !== prev_last) begin
                miscompares++;
                $display("FAIL stall_hold: got valid=%b data=%h last=%b, want valid=1 data=%h last=%b",
                         b1.o_valid, b1.o_data, b1.o_last, prev_data, prev_last);
            end
        end
        if (in_stream && exp_q.size() > 0) begin
            vectors++;
            if (b1.o_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL no_bubble: got o_valid=%b, want 1", b1.o_valid);
            end
        end
        b1.i_resultValid = rv;
        b1.i_c           = rv ? m : mat_rand();
        b1.i_ready       = rdy;
        prev_stall = (b1.o_valid === 1'b1) && !rdy;
        prev_data  = b1.o_data;
        prev_last  = b1.o_last;
        if (b1.o_valid === 1'b1 && rdy) begin
            hs_count++;
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_beat: got data=%h, want no beat", b1.o_data);
            end else begin
                ed = exp_q.pop_front();
                el = exp_last_q.pop_front();
                if (b1.o_data !== ed || b1.o_last !== el) begin
                    miscompares++;
                    $display("FAIL beat: got data=%h last=%b, want data=%h last=%b",
                             b1.o_data, b1.o_last, ed, el);
                end
            end
            in_stream = (exp_q.size() > 0);
        end
    endtask

    task automatic drain(input bit backpressure);
        bit [3:0] pat = 4'b1001;
        int i = 0;
        while (exp_q.size() > 0 && i < 400) begin
            cycle(1'b0, '0, backpressure ? pat[i % 4] : 1'b1);
            i++;
        end
        if (exp_q.size() > 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: got %0d beats outstanding, want 0", exp_q.size());
            exp_q.delete();
            exp_last_q.delete();
        end
        @(negedge clk);
        vectors++;
        if (b1.o_valid !== 1'b0 || b1.o_last !== 1'b0 || b1.o_canAccept !== 1'b1) begin
            miscompares++;
            $display("FAIL idle_after_drain: got valid=%b last=%b canAccept=%b, want 0 0 1",
                     b1.o_valid, b1.o_last, b1.o_canAccept);
        end
        prev_stall = 1'b0;
        in_stream  = 1'b0;
    endtask

    task automatic advance_to(input int hs_target);
        for (int i = 0; i < 60 && hs_count < hs_target; i++) cycle(1'b0, '0, 1'b1);
    endtask

    task automatic test_reset();
        srst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        vectors++;
        if (b1.o_valid !== 1'b0 || b1.o_last !== 1'b0 || b1.o_canAccept !== 1'b1 || b1.o_data !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_epb1: got valid=%b last=%b canAccept=%b data=%h, want 0 0 1 00",
                     b1.o_valid, b1.o_last, b1.o_canAccept, b1.o_data);
        end
        vectors++;
        if (b4.o_valid !== 1'b0 || b4.o_last !== 1'b0 || b4.o_canAccept !== 1'b1 || b4.o_data !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_epb4: got valid=%b last=%b canAccept=%b data=%h, want 0 0 1 0",
                     b4.o_valid, b4.o_last, b4.o_canAccept, b4.o_data);
        end
`ifdef SYSTOLIC_STREAMER_OVERRUN_EN
        vectors++;
        if (b1.o_overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_overrun: got %b, want 0", b1.o_overrun);
        end
`endif
        srst = 1'b0;
    endtask

    task automatic test_single();
        push_matrix(mat_rc());
        cycle(1'b1, mat_rc(), 1'b1);
        vectors++;
        if (b1.o_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL latency_pulse_cycle: got o_valid=%b, want 0", b1.o_valid);
        end
        @(posedge clk); #1;
        vectors++;
        if (b1.o_valid !== 1'b1 || b1.o_data !== 8'h00) begin
            miscompares++;
            $display("FAIL latency_next_cycle: got valid=%b data=%h, want 1 00", b1.o_valid, b1.o_data);
        end
        drain(1'b0);
    endtask

    task automatic test_backpressure();
        int hs0 = hs_count;
        push_matrix(mat_rc());
        cycle(1'b1, mat_rc(), 1'b1);
        drain(1'b1);
        vectors++;
        if (hs_count - hs0 !== 16) begin
            miscompares++;
            $display("FAIL bp_handshakes: got %0d, want 16", hs_count - hs0);
        end
    endtask

    task automatic test_back_to_back();
        int hs0 = hs_count;
        push_matrix(mat_fill(8'hAA));
        cycle(1'b1, mat_fill(8'hAA), 1'b1);
        advance_to(hs0 + 5);
        push_matrix(mat_fill(8'hBB));
        cycle(1'b1, mat_fill(8'hBB), 1'b1);
        @(posedge clk); #1;
        vectors++;
        if (b1.o_canAccept !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_canAccept: got %b, want 0", b1.o_canAccept);
        end
        drain(1'b0);
    endtask

    task automatic test_triple();
        int hs0 = hs_count;
        push_matrix(mat_fill(8'hAA));
        cycle(1'b1, mat_fill(8'hAA), 1'b1);
        advance_to(hs0 + 3);
        push_matrix(mat_fill(8'hBB));
        cycle(1'b1, mat_fill(8'hBB), 1'b1);
        advance_to(hs0 + 8);
        cycle(1'b1, mat_fill(8'hCC), 1'b1);
        drain(1'b0);
`ifdef SYSTOLIC_STREAMER_OVERRUN_EN
        vectors++;
        if (b1.o_overrun !== 1'b1) begin
            miscompares++;
            $display("FAIL overrun_set: got %b, want 1", b1.o_overrun);
        end
        b1.i_clearOverrun = 1'b1;
        @(negedge clk);
        b1.i_clearOverrun = 1'b0;
        vectors++;
        if (b1.o_overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL overrun_clear: got %b, want 0", b1.o_overrun);
        end
`endif
    endtask

    task automatic test_coincident();
        int hs0;
        push_matrix(mat_fill(8'h77));
        cycle(1'b1, mat_fill(8'h77), 1'b1);
        for (int i = 0; i < 60 && exp_q.size() > 1; i++) cycle(1'b0, '0, 1'b1);
        push_matrix(mat_rc());
        cycle(1'b1, mat_rc(), 1'b1);
        @(posedge clk); #1;
        vectors++;
        if (b1.o_valid !== 1'b1 || b1.o_data !== 8'h00 || b1.o_canAccept !== 1'b1) begin
            miscompares++;
            $display("FAIL coincident_reload: got valid=%b data=%h canAccept=%b, want 1 00 1",
                     b1.o_valid, b1.o_data, b1.o_canAccept);
        end
        drain(1'b0);
        // Last beat of active with pending full plus a fresh capture: nothing dropped.
        hs0 = hs_count;
        push_matrix(mat_fill(8'h11));
        cycle(1'b1, mat_fill(8'h11), 1'b1);
        advance_to(hs0 + 2);
        push_matrix(mat_fill(8'h22));
        cycle(1'b1, mat_fill(8'h22), 1'b1);
        advance_to(hs0 + 15);
        push_matrix(mat_rc());
        cycle(1'b1, mat_rc(), 1'b1);
        @(posedge clk); #1;
        vectors++;
        if (b1.o_canAccept !== 1'b0) begin
            miscompares++;
            $display("FAIL pend_coincident_canAccept: got %b, want 0", b1.o_canAccept);
        end
        drain(1'b0);
`ifdef SYSTOLIC_STREAMER_OVERRUN_EN
        vectors++;
        if (b1.o_overrun !== 1'b0) begin
            miscompares++;
            $display("FAIL pend_coincident_overrun: got %b, want 0", b1.o_overrun);
        end
`endif
    endtask

    task automatic test_epb4_reset();
        logic [31:0] e4;
        @(negedge clk);
        push_matrix4(mat_rc());
        b4.i_c = mat_rc(); b4.i_resultValid = 1'b1; b4.i_ready = 1'b0;
        @(negedge clk);
        b4.i_c = mat_rand(); b4.i_resultValid = 1'b0; b4.i_ready = 1'b1;
        vectors++;
        if (b4.o_valid !== 1'b1 || b4.o_data !== 32'h03020100 || b4.o_last !== 1'b0) begin
            miscompares++;
            $display("FAIL epb4_beat0: got valid=%b data=%h last=%b, want 1 03020100 0",
                     b4.o_valid, b4.o_data, b4.o_last);
        end
        void'(exp4_q.pop_front());
        @(negedge clk);
        e4 = exp4_q.pop_front();
        vectors++;
        if (b4.o_data !== e4) begin
            miscompares++;
            $display("FAIL epb4_beat1: got %h, want %h", b4.o_data, e4);
        end
        @(negedge clk);
        srst = 1'b1;
        exp4_q.delete();
        @(negedge clk);
        srst = 1'b0;
        vectors++;
        if (b4.o_valid !== 1'b0 || b4.o_canAccept !== 1'b1 || b4.o_last !== 1'b0 || b4.o_data !== 32'h0) begin
            miscompares++;
            $display("FAIL epb4_midstream_reset: got valid=%b canAccept=%b last=%b data=%h, want 0 1 0 0",
                     b4.o_valid, b4.o_canAccept, b4.o_last, b4.o_data);
        end
        push_matrix4(mat_rc());
        b4.i_c = mat_rc(); b4.i_resultValid = 1'b1;
        @(negedge clk);
        b4.i_resultValid = 1'b0; b4.i_c = mat_rand();
        for (int k = 0; k < 4; k++) begin
            e4 = exp4_q.pop_front();
            vectors++;
            if (b4.o_valid !== 1'b1 || b4.o_data !== e4 || b4.o_last !== (k == 3)) begin
                miscompares++;
                $display("FAIL epb4_restream_beat%0d: got valid=%b data=%h last=%b, want 1 %h %b",
                         k, b4.o_valid, b4.o_data, b4.o_last, e4, (k == 3));
            end
            @(negedge clk);
        end
        vectors++;
        if (b4.o_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL epb4_idle: got o_valid=%b, want 0", b4.o_valid);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish by 200us, want finish");
        $fatal(1);
    end

    initial begin
        srst = 1'b1;
        b1.i_c = '0; b1.i_resultValid = 1'b0; b1.i_ready = 1'b0;
        b4.i_c = '0; b4.i_resultValid = 1'b0; b4.i_ready = 1'b0;
`ifdef SYSTOLIC_STREAMER_OVERRUN_EN
        b1.i_clearOverrun = 1'b0;
        b4.i_clearOverrun = 1'b0;
`endif
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_triple();
        test_coincident();
        test_epb4_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
